// File: rtl/sudoku_board_dp.sv
// Sudoku board datapath: solution/player boards, LFSR difficulty masking,
// move validation and a one-cell-per-cycle correctness scan.
module sudoku_board_dp #(
    parameter int         BOX       = 2,
    parameter int         VW        = $clog2(BOX*BOX+1),
    parameter int         CW        = $clog2(BOX*BOX*BOX*BOX),
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic            clka,
    input  logic            restart_n,
    input  logic            load_valid,
    input  logic [CW-1:0]   load_cell,
    input  logic [VW-1:0]   load_val,
    input  logic            load_done,
    input  logic [1:0]      diff,
    input  logic [7:0]      seed,
    input  logic            move_valid,
    input  logic [CW-1:0]   move_cell,
    input  logic [VW-1:0]   move_val,
    output logic            move_ack,
    output logic            move_rej,
    input  logic            check_req,
    output logic            check_busy,
    output logic            check_done,
    output logic            solved,
    output logic [CW:0]     err_count,
    input  logic            try_again,
    input  logic            new_game,
    output logic [BOX*BOX*BOX*BOX-1:0] fill_flag,
    input  logic [CW-1:0]   rd_cell,
    output logic [VW-1:0]   rd_user_val,
    output logic [VW-1:0]   rd_real_val
);
    localparam int N = BOX*BOX;
    localparam int C = N*N;
    localparam logic [CW:0]   C_W  = (CW+1)'(C);
    localparam logic [VW-1:0] N_V  = VW'(N);
    localparam logic [CW-1:0] LAST = CW'(C-1);

    typedef enum logic [2:0] {S_LOAD, S_MASK, S_PLAY, S_CHECK, S_WIN} state_t;

    state_t        state_q, state_d;
    logic [VW-1:0] real_q [C];
    logic [VW-1:0] user_q [C];
    logic [7:0]    lfsr_q;
    logic [1:0]    thr_q;
    logic [CW-1:0] idx_q;

    logic          idx_last, load_ok, move_cell_ok, move_fixed, move_ok;
    logic          hide, mism, play, win, clr_edit, move_take, wr_user;
    logic [4:0]    thresh;
    logic [7:0]    lfsr_nxt;
    logic [CW:0]   err_next;

    assign idx_last     = idx_q == LAST;
    assign load_ok      = load_valid && ({1'b0, load_cell} < C_W) &&
                          load_val != '0 && load_val <= N_V;
    assign move_cell_ok = {1'b0, move_cell} < C_W;
    assign move_fixed   = move_cell_ok ? fill_flag[move_cell] : 1'b0;
    assign move_ok      = move_cell_ok && move_val <= N_V && !move_fixed;
    assign lfsr_nxt     = {lfsr_q[6:0],
                           lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign hide         = {1'b0, lfsr_q[3:0]} < thresh;
    assign mism         = user_q[idx_q] != real_q[idx_q];
    assign err_next     = err_count + {{CW{1'b0}}, mism};

    // check_req outranks try_again, which in turn drops a same-cycle move
    assign play      = state_q == S_PLAY && !new_game;
    assign win       = state_q == S_WIN && !new_game;
    assign clr_edit  = (play && !check_req && try_again) || (win && try_again);
    assign move_take = move_valid &&
                       ((play && (check_req || !try_again)) || (win && !try_again));
    assign wr_user   = move_take && play && move_ok;

    assign check_busy  = state_q == S_CHECK;
    assign rd_user_val = ({1'b0, rd_cell} < C_W) ? user_q[rd_cell] : '0;
    assign rd_real_val = ({1'b0, rd_cell} < C_W) ? real_q[rd_cell] : '0;

    always_comb begin
        thresh = 5'd0;
        unique case (thr_q)
            2'd0: thresh = 5'd0;
            2'd1: thresh = 5'd6;
            2'd2: thresh = 5'd11;
            2'd3: thresh = 5'd16;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD:  if (load_done) state_d = S_MASK;
            S_MASK:  if (new_game) state_d = S_LOAD;
                     else if (idx_last) state_d = S_PLAY;
            S_PLAY:  if (new_game) state_d = S_LOAD;
                     else if (check_req) state_d = S_CHECK;
            S_CHECK: if (new_game) state_d = S_LOAD;
                     else if (idx_last)
                         state_d = (err_next == '0) ? S_WIN : S_PLAY;
            S_WIN:   if (new_game) state_d = S_LOAD;
                     else if (try_again) state_d = S_PLAY;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q    <= S_LOAD;
            lfsr_q     <= LFSR_SEED;
            thr_q      <= 2'd0;
            idx_q      <= '0;
            move_ack   <= 1'b0;
            move_rej   <= 1'b0;
            check_done <= 1'b0;
            solved     <= 1'b0;
            err_count  <= '0;
            fill_flag  <= '0;
            for (int i = 0; i < C; i++) begin
                real_q[i] <= '0;
                user_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            move_ack   <= wr_user;
            move_rej   <= move_take && !wr_user;
            check_done <= 1'b0;
            unique case (state_q)
                S_LOAD: begin
                    if (load_ok) real_q[load_cell] <= load_val;
                    if (load_done) begin
                        thr_q <= diff;
                        idx_q <= '0;
                        if (seed != 8'd0) lfsr_q <= seed;
                    end
                end
                S_MASK: begin
                    user_q[idx_q]    <= hide ? '0 : real_q[idx_q];
                    fill_flag[idx_q] <= !hide;
                    lfsr_q           <= lfsr_nxt;
                    idx_q            <= idx_q + 1'b1;
                end
                S_PLAY: begin
                    if (play && check_req) begin
                        err_count <= '0;
                        idx_q     <= '0;
                    end
                end
                S_CHECK: begin
                    if (!new_game) begin
                        err_count <= err_next;
                        idx_q     <= idx_q + 1'b1;
                        if (idx_last) begin
                            check_done <= 1'b1;
                            solved     <= err_next == '0;
                        end
                    end
                end
                S_WIN: if (win && try_again) solved <= 1'b0;
                default: ;
            endcase
            if (wr_user) user_q[move_cell] <= move_val;
            if (clr_edit) begin
                for (int i = 0; i < C; i++)
                    if (!fill_flag[i]) user_q[i] <= '0;
            end
            // real board and LFSR survive a new game
            if (new_game && state_q != S_LOAD) begin
                fill_flag <= '0;
                solved    <= 1'b0;
                err_count <= '0;
                for (int i = 0; i < C; i++) user_q[i] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sudoku_board_dp.sv
// Directed scoreboard bench for sudoku_board_dp (BOX=2 and BOX=3 instances).
module tb_sudoku_board_dp;
    logic clka = 1'b0;
    always #5 clka = ~clka;
    logic restart_n;

    logic        load_valid, load_done, move_valid, check_req, try_again, new_game;
    logic [3:0]  load_cell, move_cell, rd_cell;
    logic [2:0]  load_val, move_val;
    logic [1:0]  diff;
    logic [7:0]  seed;
    logic        move_ack, move_rej, check_busy, check_done, solved;
    logic [4:0]  err_count;
    logic [15:0] fill_flag;
    logic [2:0]  rd_user_val, rd_real_val;

    logic        lv3, ld3, mv3, cr3, ta3, ng3;
    logic [6:0]  lc3, mc3, rc3;
    logic [3:0]  lval3, mval3;
    logic [1:0]  diff3;
    logic [7:0]  seed3;
    logic        ack3, rej3, busy3, done3, solved3;
    logic [7:0]  err3;
    logic [80:0] ff3;
    logic [3:0]  ru3, rr3;

    sudoku_board_dp #(.BOX(2)) dut (
        .clka(clka), .restart_n(restart_n),
        .load_valid(load_valid), .load_cell(load_cell), .load_val(load_val),
        .load_done(load_done), .diff(diff), .seed(seed),
        .move_valid(move_valid), .move_cell(move_cell), .move_val(move_val),
        .move_ack(move_ack), .move_rej(move_rej),
        .check_req(check_req), .check_busy(check_busy), .check_done(check_done),
        .solved(solved), .err_count(err_count),
        .try_again(try_again), .new_game(new_game), .fill_flag(fill_flag),
        .rd_cell(rd_cell), .rd_user_val(rd_user_val), .rd_real_val(rd_real_val)
    );

    sudoku_board_dp #(.BOX(3)) dut3 (
        .clka(clka), .restart_n(restart_n),
        .load_valid(lv3), .load_cell(lc3), .load_val(lval3),
        .load_done(ld3), .diff(diff3), .seed(seed3),
        .move_valid(mv3), .move_cell(mc3), .move_val(mval3),
        .move_ack(ack3), .move_rej(rej3),
        .check_req(cr3), .check_busy(busy3), .check_done(done3),
        .solved(solved3), .err_count(err3),
        .try_again(ta3), .new_game(ng3), .fill_flag(ff3),
        .rd_cell(rc3), .rd_user_val(ru3), .rd_real_val(rr3)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [2:0] sol [16] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd1, 3'd2,
                             3'd2, 3'd1, 3'd4, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1};
    logic [1:0] mq [$];
    logic [5:0] cq [$];

    function automatic logic [7:0] lf_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [3:0] sol3(input int i);
        int r, c;
        r = i / 9;
        c = i % 9;
        return 4'(((r * 3 + r / 3 + c) % 9) + 1);
    endfunction

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_user(input string tag, input logic [15:0] shown);
        for (int i = 0; i < 16; i++) begin
            rd_cell = 4'(i);
            #1;
            chk(tag, rd_user_val, shown[i] ? sol[i] : 3'd0);
        end
    endtask

    task automatic step_move(input int c, input int v, input bit ea,
                             input bit er, input bit cr, input bit ta);
        logic [1:0] e;
        move_valid = 1'b1;
        move_cell  = 4'(c);
        move_val   = 3'(v);
        check_req  = cr;
        try_again  = ta;
        mq.push_back({ea, er});
        tick();
        move_valid = 1'b0;
        check_req  = 1'b0;
        try_again  = 1'b0;
        e = mq.pop_front();
        chk("move_ack", move_ack, e[1]);
        chk("move_rej", move_rej, e[0]);
    endtask

    task automatic wait_check();
        int lat;
        logic [5:0] e;
        lat = 0;
        chk("check_busy_on", check_busy, 1);
        while (!check_done && lat < 200) begin
            tick();
            lat++;
        end
        e = cq.pop_front();
        chk("check_latency", lat, 16);
        chk("check_busy_off", check_busy, 0);
        chk("solved", solved, e[5]);
        chk("err_count", err_count, e[4:0]);
        tick();
        chk("check_done_pulse", check_done, 0);
    endtask

    task automatic run_check(input bit s, input int e);
        cq.push_back({s, 5'(e)});
        check_req = 1'b1;
        tick();
        check_req = 1'b0;
        wait_check();
    endtask

    task automatic do_mask(input logic [1:0] d, input logic [7:0] s);
        load_done = 1'b1;
        diff = d;
        seed = s;
        tick();
        load_done = 1'b0;
        seed = 8'd0;
        repeat (16) tick();
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    initial begin
        logic [7:0]  l;
        logic [15:0] show;
        int lat;
        bit seen;
        restart_n = 1'b0;
        {load_valid, load_done, move_valid, check_req, try_again, new_game} = '0;
        load_cell = '0; load_val = '0; move_cell = '0; move_val = '0;
        rd_cell = '0; diff = '0; seed = '0;
        {lv3, ld3, mv3, cr3, ta3, ng3} = '0;
        lc3 = '0; mc3 = '0; rc3 = '0; lval3 = '0; mval3 = '0;
        diff3 = '0; seed3 = '0;
        #2;
        chk("rst_ack_rej", {move_ack, move_rej}, 0);
        chk("rst_busy_done", {check_busy, check_done}, 0);
        chk("rst_solved", solved, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fill", fill_flag, 0);
        chk("rst_rd", {rd_user_val, rd_real_val}, 0);
        #10 restart_n = 1'b1;
        tick();

        // load solution, plus loads that must be ignored
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1;
            load_cell = 4'(i);
            load_val = sol[i];
            tick();
        end
        load_cell = 4'd0; load_val = 3'd5; tick();
        load_val = 3'd0; tick();
        load_valid = 1'b0;
        rd_cell = 4'd0; #1;
        chk("real0_kept", rd_real_val, 1);
        rd_cell = 4'd6; #1;
        chk("real6", rd_real_val, 1);

        load_done = 1'b1; diff = 2'd0;
        tick();
        load_done = 1'b0;
        repeat (15) tick();
        chk("mask_partial", fill_flag, 16'h7FFF);
        tick();
        chk("mask_full", fill_flag, 16'hFFFF);
        chk_user("user_eq_real", 16'hFFFF);
        step_move(5, 4, 0, 1, 0, 0);
        run_check(1, 0);
        step_move(5, 4, 0, 1, 0, 0);

        pulse_new_game();
        chk("ng_fill", fill_flag, 0);
        chk("ng_solved", solved, 0);
        rd_cell = 4'd0; #1;
        chk("ng_user0", rd_user_val, 0);
        chk("ng_real_kept", rd_real_val, 1);

        // all cells hidden
        do_mask(2'd3, 8'd0);
        chk("hide_all_fill", fill_flag, 0);
        chk_user("hide_all_user", 16'h0000);
        run_check(0, 16);
        for (int i = 0; i < 16; i++) step_move(i, sol[i], 1, 0, 0, 0);
        run_check(1, 0);
        try_again = 1'b1;
        tick();
        try_again = 1'b0;
        chk("win_retry_solved", solved, 0);
        chk_user("win_retry_clear", 16'h0000);

        // single wrong cell
        for (int i = 0; i < 16; i++)
            step_move(i, (i == 7) ? 1 : int'(sol[i]), 1, 0, 0, 0);
        run_check(0, 1);
        step_move(7, 2, 1, 0, 0, 0);
        run_check(1, 0);
        step_move(3, 1, 0, 1, 0, 0);

        pulse_new_game();
        do_mask(2'd3, 8'd0);
        step_move(0, 5, 0, 1, 0, 0);
        step_move(0, 1, 1, 0, 0, 0);
        step_move(0, 0, 1, 0, 0, 0);
        rd_cell = 4'd0; #1;
        chk("clear_cell0", rd_user_val, 0);
        for (int i = 0; i < 15; i++) step_move(i, sol[i], 1, 0, 0, 0);
        cq.push_back({1'b1, 5'd0});
        step_move(15, sol[15], 1, 0, 1, 0);
        wait_check();
        try_again = 1'b1;
        tick();
        try_again = 1'b0;
        chk_user("retry_clear", 16'h0000);
        step_move(3, sol[3], 0, 0, 0, 1);
        rd_cell = 4'd3; #1;
        chk("move_dropped", rd_user_val, 0);

        // LFSR-driven masking against a reference model
        pulse_new_game();
        l = 8'h5A;
        for (int i = 0; i < 16; i++) begin
            show[i] = !(l[3:0] < 4'd6);
            l = lf_next(l);
        end
        do_mask(2'd1, 8'h5A);
        chk("lfsr_d1_fill", fill_flag, show);
        chk_user("lfsr_d1_user", show);
        pulse_new_game();
        for (int i = 0; i < 16; i++) begin
            show[i] = !(l[3:0] < 4'd11);
            l = lf_next(l);
        end
        do_mask(2'd2, 8'd0);
        chk("lfsr_d2_fill", fill_flag, show);
        chk_user("lfsr_d2_user", show);

        // reset during a scan
        check_req = 1'b1;
        tick();
        check_req = 1'b0;
        repeat (7) tick();
        restart_n = 1'b0;
        #1;
        chk("abort_busy", check_busy, 0);
        chk("abort_done", check_done, 0);
        chk("abort_solved_err", {solved, err_count}, 0);
        chk("abort_fill", fill_flag, 0);
        rd_cell = 4'd0; #1;
        chk("abort_real", rd_real_val, 0);
        #3 restart_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (check_done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        step_move(0, 1, 0, 0, 0, 0);
        load_valid = 1'b1; load_cell = 4'd0; load_val = 3'd3;
        tick();
        load_valid = 1'b0;
        chk("abort_in_load", rd_real_val, 3);

        // 9x9 board
        for (int i = 0; i < 81; i++) begin
            lv3 = 1'b1;
            lc3 = 7'(i);
            lval3 = sol3(i);
            tick();
        end
        lv3 = 1'b0;
        ld3 = 1'b1; diff3 = 2'd0; seed3 = 8'h3C;
        tick();
        ld3 = 1'b0;
        repeat (80) tick();
        chk("b3_mask_partial", ff3, {1'b0, {80{1'b1}}});
        tick();
        chk("b3_mask_full", ff3, {81{1'b1}});
        rc3 = 7'd40; #1;
        chk("b3_user40", ru3, sol3(40));
        mv3 = 1'b1; mc3 = 7'd81; mval3 = 4'd1;
        tick();
        mv3 = 1'b0;
        chk("b3_rej_cell", {ack3, rej3}, 2'b01);
        mv3 = 1'b1; mc3 = 7'd3; mval3 = 4'd10;
        tick();
        mv3 = 1'b0;
        chk("b3_rej_val", {ack3, rej3}, 2'b01);
        cr3 = 1'b1;
        tick();
        cr3 = 1'b0;
        chk("b3_busy", busy3, 1);
        lat = 0;
        while (!done3 && lat < 300) begin
            tick();
            lat++;
        end
        chk("b3_latency", lat, 81);
        chk("b3_solved", solved3, 1);
        chk("b3_err", err3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sudoku_board_dp.md
# sudoku_board_dp

Parametrised single-clock Sudoku board datapath and control: the next generation of the fixed 4x4 two-phase datapath. Board side N = BOX*BOX (BOX=2 gives 4x4, BOX=3 gives 9x9). It stores the solution ("real") board and the player ("user") board, masks cells by difficulty with an on-chip LFSR, validates player moves, and runs a multi-cycle correctness scan. It sits between the game FSM/input front-end and the display driver.

## Interface
- BOX, 2, box side; N = BOX*BOX, C = N*N cells (derived).
- VW, $clog2(BOX*BOX+1), value width; 0 means empty.
- CW, $clog2(BOX*BOX*BOX*BOX), cell index width (row-major).
- LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero).
- clka  in  1  clock, rising edge.
- restart_n  in  1  reset, asynchronous, active-low.
- load_valid, load_cell[CW], load_val[VW]  in  write the real board in LOAD.
- load_done  in  1  end of load; samples diff and seed.
- diff  in  2  difficulty.
- seed  in  8  LFSR reseed; 0 means keep the current value.
- move_valid, move_cell[CW], move_val[VW]  in  player move.
- move_ack, move_rej  out  1  registered one-cycle pulses.
- check_req  in  1  start the correctness scan.
- check_busy  out  1  high in CHECK.
- check_done  out  1  one-cycle pulse at the end of the scan.
- solved  out  1  result of the last scan; held.
- err_count  out  CW+1  mismatches from the last scan; held.
- try_again, new_game  in  1  control.
- fill_flag  out  C  1 = fixed (given) cell.
- rd_cell  in  CW; rd_user_val, rd_real_val  out  VW  combinational read of the registers.

## Operation
- States: LOAD (reset state), MASK, PLAY, CHECK, WIN.
- LOAD:
  - load_valid with load_cell<C and 1<=load_val<=N writes real[load_cell]; other loads are ignored.
  - load_done: latch diff into thr; if seed!=0, lfsr<=seed; go to MASK with idx=0.
- MASK: one cell per cycle, idx 0..C-1.
  - Hide the cell if lfsr[3:0] < T, where T = {0,6,11,16}[thr].
  - Hidden cell: user=0, fill_flag=0. Shown cell: user=real, fill_flag=1.
  - The LFSR advances every MASK cycle: 8-bit Fibonacci, shift left, bit0 <= b7^b5^b4^b3.
  - After cell C-1, go to PLAY.
- PLAY:
  - move_valid is rejected (move_rej) if move_cell>=C, move_val>N, or fill_flag[move_cell]=1.
  - Otherwise user[move_cell]<=move_val (0 clears the cell) and move_ack pulses.
  - try_again: every cell with fill_flag=0 is set to 0 in one cycle.
  - check_req: clear err_count, idx=0, go to CHECK.
- CHECK: one cell per cycle; err_count increments when user[idx]!=real[idx].
  - After cell C-1: pulse check_done; solved<=(final count==0); go to WIN if solved, else PLAY.
  - move_valid, try_again and check_req are ignored in CHECK; moves produce no ack and no rej.
- WIN: board frozen; moves are rejected. try_again returns to PLAY with the editable cells cleared, and clears solved.
- new_game (any state except LOAD): go to LOAD and clear fill_flag, user, solved, err_count. The real board is kept; the LFSR is not reset.
- Precedence within a cycle: new_game > check_req > try_again > move.
  - A move in the same cycle as check_req is applied first and is counted by the scan.
  - A move in the same cycle as try_again is dropped; no ack and no rej.

## Timing
- Reset values (async, immediate): state LOAD, real/user/fill_flag all 0, lfsr=LFSR_SEED, idx 0, and move_ack, move_rej, check_busy, check_done, solved, err_count all 0.
- restart_n low mid-MASK or mid-CHECK aborts the operation with no check_done.
- move_ack/move_rej: the cycle after move_valid is sampled. At most one of them is high in a cycle.
- load_done sampled at edge t: MASK runs cycles t+1..t+C; PLAY from t+C+1.
- check_req sampled at edge t: check_busy high t+1..t+C; check_done, solved and err_count valid at t+C+1, with check_busy low.
- rd_user_val/rd_real_val reflect the register state after the most recent edge.
- Latency scales with BOX: 16-cycle scan for BOX=2, 81-cycle scan for BOX=3.

## Test plan
- Load solution 1234/3412/2143/4321 (BOX=2), diff=0, load_done -> after 16 cycles fill_flag=16'hFFFF and user==real. Move to cell 5 -> move_rej. check_req -> check_done 17 cycles later, solved=1, err_count=0, state WIN.
- Same solution, diff=3 -> fill_flag=0, all user cells 0. check -> solved=0, err_count=16. Write all 16 correct values (16 acks) and check -> solved=1.
- diff=3, fill all cells correctly except cell 7=1 -> err_count=1, solved=0, back in PLAY. Fix cell 7 to 2 and recheck -> solved=1.
- move_val=5 -> move_rej. move_valid+check_req in the same cycle -> the move is written and counted by the scan. try_again -> all editable cells read 0.
- Reset: assert restart_n at cycle 8 of a CHECK -> all outputs 0 at once, no check_done, state LOAD.
- From WIN, new_game -> LOAD with fill_flag=0. BOX=3 with a 9x9 solution and diff=0 -> 81-cycle MASK, solved=1 after an 81-cycle scan.
